ahb_regbank: RTL and testbench
==============================

# ahb_regbank

Parametrised AHB slave register bank: NUM_REGS registers of DATA_W bits behind a single-clock AHB slave port with configurable wait states and two-cycle error response. Uses the same bus signal set as the team's AHB verification interface, adding HRESP. Sits on the AHB fabric as a configuration target; register contents are exported in parallel on REG_Q to the datapath it configures.

## Interface
- DATA_W, 32, data bus and register width; multiple of 8, at most 64
- ADDR_W, 32, address bus width
- NUM_REGS, 8, register count; 1..256
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_W/8
- WAIT_STATES, 0, data-phase wait cycles for OKAY transfers; 0..15

- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select
- HTRANS  in  1  1 = active transfer, 0 = idle
- HADDR  in  ADDR_W  byte address
- HWRITE  in  1  1 = write, 0 = read
- HREADY  in  1  bus-level ready; address phase accepted only when high
- HWDATA  in  DATA_W  write data, valid in the data phase
- HREADY_RESP  out  1  slave ready; low stalls the data phase
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_W  read data
- REG_Q  out  NUM_REGS*DATA_W  register contents, register i at bits [i*DATA_W +: DATA_W]

## Operation
- Accept: HSEL & HTRANS & HREADY at a rising edge. Latch write flag, register index and error flag.
- Index = (HADDR − BASE_ADDR) / (DATA_W/8).
- Error when any of the following holds: HADDR < BASE_ADDR; index ≥ NUM_REGS; HADDR not aligned to DATA_W/8.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
- Exit from IDLE, or from any state's final cycle on a new accept:
  - error transfer → ERR1
  - OKAY transfer, WAIT_STATES > 0 → WAIT, counter loaded with WAIT_STATES−1
  - OKAY transfer, WAIT_STATES = 0 → LAST
- WAIT: HREADY_RESP=0, HRESP=0. Counter decrements each cycle; at 0 → LAST.
- LAST: HREADY_RESP=1, HRESP=0.
  - Write: register[index] ← HWDATA at the edge ending LAST.
  - Read: HRDATA holds register[index].
  - At that edge, go to IDLE or accept the next transfer (back-to-back).
- ERR1: HREADY_RESP=0, HRESP=1 → ERR2.
- ERR2: HREADY_RESP=1, HRESP=1 → IDLE or next accept.
- Error transfers never modify registers, and HRDATA stays 0.
- HRDATA is registered and is 0 in every cycle except LAST of a read.
- REG_Q is a direct register view and updates the cycle after the write commit.

## Timing
- Reset values (asynchronous, immediate):
  - FSM in IDLE
  - HREADY_RESP=1, HRESP=0, HRDATA=0, all registers and REG_Q = 0
  - wait counter = 0
- Reset during WAIT/LAST/ERR aborts the transfer; a pending write is discarded.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles. The error data phase always lasts 2 cycles.
- Back-to-back transfers: a new address phase overlaps the previous LAST/ERR2 cycle, so there is no idle cycle between data phases.
- Write-then-read to the same register, back-to-back: the read returns the newly written HWDATA. With WAIT_STATES=0 this requires forwarding HWDATA into HRDATA at the shared edge.
- Accept while HREADY=0 is ignored, whatever HSEL/HTRANS are.
- HSEL=1 with HTRANS=0 is ignored: no state change, OKAY with HREADY_RESP=1.
- Address index arithmetic is done in ADDR_W bits. The subtraction must not wrap into a valid index; HADDR < BASE_ADDR is checked first.

## Test plan
- Reset: hold RST_N=0 → HREADY_RESP=1, HRESP=0, HRDATA=0, REG_Q all 0. Release, then read reg 3 → HRDATA=0.
- WAIT_STATES=0, write 0xDEADBEEF to BASE+0x8, then immediately read BASE+0x8 back-to-back → no stall cycles, read HRDATA=0xDEADBEEF (forwarding), REG_Q[95:64]=0xDEADBEEF.
- WAIT_STATES=3, read reg 1 holding 0x12345678 → HREADY_RESP low for exactly 3 cycles, then high with HRDATA=0x12345678 for one cycle, then HRDATA=0.
- NUM_REGS=8: write to BASE+0x20 (out of range), then to BASE+0x2 (unaligned) → each gives HRESP=1 for 2 cycles (HREADY_RESP 0 then 1), and REG_Q is unchanged.
- Assert RST_N=0 in the second wait cycle of a write 0xA5A5A5A5 to reg 2 (WAIT_STATES=3) → outputs go to reset values immediately and reg 2 stays 0.
- HSEL=1, HTRANS=1, HREADY=0 with HWRITE=1 → no transfer: HREADY_RESP stays 1 and REG_Q is unchanged.

Source files
------------

// File: rtl/ahb_regbank.sv
// ahb_regbank: AHB slave register bank with configurable wait states.
//
// NUM_REGS registers of DATA_W bits sit behind a single-clock AHB slave port.
// OKAY transfers have a data phase of WAIT_STATES+1 cycles. Error transfers
// (below BASE_ADDR, beyond the last register, or unaligned) get the two-cycle
// ERROR response. Register contents are exported in parallel on reg_q.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   hsel         slave select
//   htrans       1 = active transfer, 0 = idle
//   haddr        byte address
//   hwrite       1 = write, 0 = read
//   hready       bus-level ready; address phase accepted only when high
//   hwdata       write data, valid in the data phase
//   hready_resp  slave ready; low stalls the data phase
//   hresp        0 = OKAY, 1 = ERROR
//   hrdata       registered read data, non-zero only in the last cycle of a read
//   reg_q        register i at bits [i*DATA_W +: DATA_W]
module ahb_regbank #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hsel,
    input  logic                         htrans,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic                         hwrite,
    input  logic                         hready,
    input  logic [DATA_W-1:0]            hwdata,
    output logic                         hready_resp,
    output logic                         hresp,
    output logic [DATA_W-1:0]            hrdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLast,
        StErr1,
        StErr2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                accept;
    logic                final_cycle;
    logic                reg_we;
    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   word_idx;
    logic                req_err;
    logic [IDX_W-1:0]    req_idx;

    // Address decode. The below-base test guards against the subtraction
    // wrapping around into a valid index.
    always_comb begin
        offset   = haddr - BASE_ADDR;
        word_idx = offset / ADDR_W'(BYTES);
        req_err  = (haddr < BASE_ADDR)
                || ((haddr % ADDR_W'(BYTES)) != '0)
                || (word_idx >= ADDR_W'(NUM_REGS));
        req_idx  = word_idx[IDX_W-1:0];
    end

    assign accept      = hsel & htrans & hready;
    assign final_cycle = (state_q == StIdle) || (state_q == StLast) || (state_q == StErr2);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        hrdata_d = '0;
        reg_we   = 1'b0;

        unique case (state_q)
            StIdle: ;
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StLast;
                    if (!wr_q) begin
                        hrdata_d = regs_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StLast: begin
                reg_we  = wr_q;
                state_d = StIdle;
            end
            StErr1: state_d = StErr2;
            StErr2: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // New address phase overlapping the final cycle of the previous one.
        if (final_cycle && accept) begin
            if (req_err) begin
                state_d = StErr1;
                wr_d    = 1'b0;
                idx_d   = '0;
            end else begin
                wr_d  = hwrite;
                idx_d = req_idx;
                if (WAIT_STATES > 0) begin
                    state_d = StWait;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = StLast;
                    if (!hwrite) begin
                        // A write to the same register commits on this very
                        // edge, so the read must see hwdata directly.
                        if (reg_we && (idx_q == req_idx)) begin
                            hrdata_d = hwdata;
                        end else begin
                            hrdata_d = regs_q[req_idx];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[idx_q] <= hwdata;
        end
    end

    assign hready_resp = !((state_q == StWait) || (state_q == StErr1));
    assign hresp       = (state_q == StErr1) || (state_q == StErr2);
    assign hrdata      = hrdata_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end

endmodule

// File: tb/tb_ahb_regbank.sv
// tb_ahb_regbank: two register banks (0 and 3 wait states) on separate buses,
// driven by directed and random AHB traffic and compared every cycle against
// a transaction-level model of the expected data-phase responses.
module tb_ahb_regbank;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [1:0]         hsel, htrans, hwrite, gate, hready_bus, hready_resp, hresp;
    logic [1:0][31:0]   haddr, hwdata, hrdata;
    logic [1:0][255:0]  reg_q;

    int n_vec = 0;
    int n_err = 0;

    // The bus ready seen by each slave is its own ready, optionally forced low.
    assign hready_bus = hready_resp & ~gate;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_regbank #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .NUM_REGS    (8),
            .BASE_ADDR   (BASE),
            .WAIT_STATES ((g == 0) ? 0 : 3)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .hsel        (hsel[g]),
            .htrans      (htrans[g]),
            .haddr       (haddr[g]),
            .hwrite      (hwrite[g]),
            .hready      (hready_bus[g]),
            .hwdata      (hwdata[g]),
            .hready_resp (hready_resp[g]),
            .hresp       (hresp[g]),
            .hrdata      (hrdata[g]),
            .reg_q       (reg_q[g])
        );
    end

    task automatic chk(input string name, input int k, input logic [255:0] act,
                       input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One entry per expected data-phase cycle.
    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic        commit;
        logic [2:0]  idx;
    } ph_t;

    ph_t         q_buf [2][32];
    int          q_head [2];
    int          q_cnt [2];
    logic [31:0] mreg [2][8];

    function automatic ph_t mk(logic rdy, logic resp, logic [31:0] data, logic commit,
                               logic [2:0] idx);
        ph_t p;
        p.rdy = rdy; p.resp = resp; p.data = data; p.commit = commit; p.idx = idx;
        return p;
    endfunction

    task automatic push(input int k, input ph_t p);
        q_buf[k][(q_head[k] + q_cnt[k]) % 32] = p;
        q_cnt[k]++;
    endtask

    always @(negedge clk) begin : compare
        ph_t         e;
        logic [255:0] view;
        logic [31:0] a;
        logic        err;
        int          ws;
        int unsigned widx;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                q_cnt[k]  = 0;
                q_head[k] = 0;
                for (int i = 0; i < 8; i++) mreg[k][i] = '0;
            end
            e = mk(1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
            if (q_cnt[k] > 0) e = q_buf[k][q_head[k]];
            for (int i = 0; i < 8; i++) view[i*32 +: 32] = mreg[k][i];
            chk("hready_resp", k, 256'(hready_resp[k]), 256'(e.rdy));
            chk("hresp", k, 256'(hresp[k]), 256'(e.resp));
            chk("hrdata", k, 256'(hrdata[k]), 256'(e.data));
            chk("reg_q", k, reg_q[k], view);
            if (rst_n) begin
                if (q_cnt[k] > 0) begin
                    q_head[k] = (q_head[k] + 1) % 32;
                    q_cnt[k]--;
                end
                if (e.commit) mreg[k][e.idx] = hwdata[k];
                if (e.rdy && !gate[k] && hsel[k] && htrans[k]) begin
                    a    = haddr[k];
                    ws   = (k == 0) ? 0 : 3;
                    err  = (a < BASE) || (((a - BASE) % 4) != 0) || (((a - BASE) / 4) >= 8);
                    widx = (a - BASE) / 4;
                    if (err) begin
                        push(k, mk(1'b0, 1'b1, 32'h0, 1'b0, 3'd0));
                        push(k, mk(1'b1, 1'b1, 32'h0, 1'b0, 3'd0));
                    end else begin
                        for (int w = 0; w < ws; w++) push(k, mk(1'b0, 1'b0, 32'h0, 1'b0, 3'd0));
                        if (hwrite[k]) push(k, mk(1'b1, 1'b0, 32'h0, 1'b1, 3'(widx)));
                        else push(k, mk(1'b1, 1'b0, mreg[k][widx], 1'b0, 3'(widx)));
                    end
                end
            end
        end
    end

    // ---------------- bus driver ----------------
    // Presents an address phase just after a rising edge and holds it until an
    // edge with ready high; then drives this transfer's write data.
    task automatic bus_op(input int k, input logic sel, input logic trans, input logic [31:0] addr,
                          input logic wr, input logic [31:0] wdata, output int edges);
        logic r;
        int   n;
        hsel[k] = sel; htrans[k] = trans; haddr[k] = addr; hwrite[k] = wr;
        n = 0;
        r = 1'b0;
        while (!r && n < 64) begin
            @(negedge clk);
            r = hready_bus[k];
            @(posedge clk);
            #1;
            n++;
        end
        edges = n;
        chk("bus_ready_within_budget", k, 256'(r), 256'(1));
        hwdata[k] = (sel && trans && wr) ? wdata : $urandom();
    endtask

    task automatic bus_idle(input int k);
        hsel[k] = 1'b0; htrans[k] = 1'b0;
    endtask

    // A write attempt presented while the bus ready is forced low.
    task automatic gate_hold(input int k, input int n);
        int e;
        bus_op(k, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, e);
        gate[k] = 1'b1; hsel[k] = 1'b1; htrans[k] = 1'b1; hwrite[k] = 1'b1;
        haddr[k] = BASE; hwdata[k] = $urandom();
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("hready_resp_gated", k, 256'(hready_resp[k]), 256'(1));
        end
        gate[k] = 1'b0; hsel[k] = 1'b0; htrans[k] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 99);
        if (r < 70) return BASE + 32'(4 * $urandom_range(0, 7));
        else if (r < 80) return BASE + 32'(4 * $urandom_range(8, 40));
        else if (r < 90) return BASE + 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
        else if (r < 97) return 32'($urandom_range(0, 255));
        else return 32'hFFFF_FFFC;
    endfunction

    task automatic rand_run(input int k, input int nops);
        int          e;
        int unsigned r;
        for (int i = 0; i < nops; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) bus_op(k, 1'($urandom_range(0, 1)), 1'b0, rand_addr(), 1'b1, 32'h0, e);
            else if (r < 13) gate_hold(k, int'($urandom_range(1, 3)));
            else bus_op(k, 1'b1, 1'b1, rand_addr(), 1'($urandom_range(0, 1)), $urandom(), e);
        end
        bus_op(k, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, e);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequences ----------------
    initial begin : main
        int           e;
        int           lowc;
        logic [255:0] lit;
        rst_n = 1'b0;
        hsel = '0; htrans = '0; hwrite = '0; haddr = '0; hwdata = '0; gate = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_hready_resp", k, 256'(hready_resp[k]), 256'(1));
            chk("rst_hresp", k, 256'(hresp[k]), 256'(0));
            chk("rst_hrdata", k, 256'(hrdata[k]), 256'(0));
            chk("rst_reg_q", k, reg_q[k], 256'(0));
        end
        rst_n = 1'b1;

        // Read reg 3 after reset.
        bus_op(0, 1'b1, 1'b1, BASE + 32'hC, 1'b0, 32'h0, e);
        #1 chk("rd_reg3_after_reset", 0, 256'(hrdata[0]), 256'(0));

        // Back-to-back write then read of the same register, no wait states.
        bus_op(0, 1'b1, 1'b1, BASE + 32'h8, 1'b1, 32'hDEAD_BEEF, e);
        bus_op(0, 1'b1, 1'b1, BASE + 32'h8, 1'b0, 32'h0, e);
        chk("b2b_no_stall", 0, 256'(e), 256'(1));
        #1 chk("b2b_forward_hrdata", 0, 256'(hrdata[0]), 256'(32'hDEAD_BEEF));
        lit = '0;
        lit[95:64] = 32'hDEAD_BEEF;
        chk("b2b_reg_q", 0, reg_q[0], lit);

        // Out-of-range then unaligned writes.
        bus_op(0, 1'b1, 1'b1, BASE + 32'h20, 1'b1, 32'h1111_1111, e);
        #1 chk("err1_hresp", 0, 256'(hresp[0]), 256'(1));
        chk("err1_hready_resp", 0, 256'(hready_resp[0]), 256'(0));
        bus_op(0, 1'b1, 1'b1, BASE + 32'h2, 1'b1, 32'h2222_2222, e);
        chk("err_range_len", 0, 256'(e), 256'(2));
        bus_op(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, e);
        chk("err_unaligned_len", 0, 256'(e), 256'(2));
        chk("err_reg_q_unchanged", 0, reg_q[0], lit);

        // Transfer presented while bus ready is low is ignored.
        gate_hold(0, 4);
        chk("gated_reg_q_unchanged", 0, reg_q[0], lit);

        // Three wait states.
        bus_op(1, 1'b1, 1'b1, BASE + 32'h4, 1'b1, 32'h1234_5678, e);
        bus_op(1, 1'b1, 1'b1, BASE + 32'h4, 1'b0, 32'h0, e);
        chk("ws3_write_len", 1, 256'(e), 256'(4));
        bus_idle(1);
        lowc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (hready_resp[1]) break;
            lowc++;
        end
        chk("ws3_stall_cycles", 1, 256'(lowc), 256'(3));
        chk("ws3_read_hrdata", 1, 256'(hrdata[1]), 256'(32'h1234_5678));
        @(negedge clk);
        chk("ws3_hrdata_after_last", 1, 256'(hrdata[1]), 256'(0));
        @(posedge clk);
        #1;

        // Reset in the second wait cycle of a write to reg 2.
        bus_op(1, 1'b1, 1'b1, BASE + 32'h8, 1'b1, 32'hA5A5_A5A5, e);
        bus_idle(1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_hready_resp", 1, 256'(hready_resp[1]), 256'(1));
        chk("midrst_hresp", 1, 256'(hresp[1]), 256'(0));
        chk("midrst_hrdata", 1, 256'(hrdata[1]), 256'(0));
        chk("midrst_reg_q", 0, reg_q[0], 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_op(1, 1'b1, 1'b1, BASE + 32'h8, 1'b0, 32'h0, e);
        bus_op(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, e);
        chk("midrst_read_len", 1, 256'(e), 256'(4));
        chk("midrst_reg2_discarded", 1, reg_q[1], 256'(0));

        // Random traffic on both banks in parallel.
        fork
            rand_run(0, 300);
            rand_run(1, 300);
        join
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
